// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_defs_pkg
// Description : Shared definitions for the execute-stage ALU. Holds the
//               ALU_OP encoding (also used by ctrl_unit so both ends agree),
//               the mul/div FSM state encoding and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_defs_pkg;

    localparam int XLEN_DEFAULT = 32;

    // ALU_OP encoding in ctrl_unit order
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SLL    = 5'b00001;
    localparam logic [4:0] ALU_SLT    = 5'b00010;
    localparam logic [4:0] ALU_SLTU   = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SRL    = 5'b00101;
    localparam logic [4:0] ALU_OR     = 5'b00110;
    localparam logic [4:0] ALU_AND    = 5'b00111;
    localparam logic [4:0] ALU_SUB    = 5'b10000;
    localparam logic [4:0] ALU_SRA    = 5'b10101;
    localparam logic [4:0] ALU_MUL    = 5'b11000;
    localparam logic [4:0] ALU_MULH   = 5'b11001;
    localparam logic [4:0] ALU_MULHSU = 5'b11010;
    localparam logic [4:0] ALU_MULHU  = 5'b11011;
    localparam logic [4:0] ALU_DIV    = 5'b11100;
    localparam logic [4:0] ALU_REM    = 5'b11101;
    localparam logic [4:0] ALU_DIVU   = 5'b11110;
    localparam logic [4:0] ALU_REMU   = 5'b11111;

    // Iterative engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Iterative XLEN-step multiply / restoring-divide engine.
//               Operands are converted to magnitudes on start, one bit is
//               processed per clock, and signs/word selection are applied in
//               the FIX state, where done_o is high for one cycle.
// Ports       : clk_i, rst_ni (sync, active-low), start_i (accept, IDLE only),
//               op_i {is_div, ALU_OP[1:0]}, a_i/b_i operands, flush_i (abort),
//               busy_o (not IDLE), done_o (FIX), result_o (valid with done_o)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
    import alu_defs_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d;   // product high word / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;   // multiplier bits / dividend -> quotient
    logic [XLEN-1:0] m_q, m_d;     // multiplicand or divisor magnitude
    logic            neg_q, neg_d; // negate the selected result in FIX
    logic [2:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            w_sa, w_sb, w_neg_a, w_neg_b, w_div0, w_ovf;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_addend, w_diff, w_quot, w_rem;
    logic [XLEN:0]   w_sum, w_rsh;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod;

    // Operand signedness: MULHU, DIVU, REMU are unsigned; MULHSU only on a.
    assign w_sa    = op_i[2] ? ~op_i[1] : ~(op_i[1] & op_i[0]);
    assign w_sb    = ~op_i[1];
    assign w_neg_a = w_sa & a_i[XLEN-1];
    assign w_neg_b = w_sb & b_i[XLEN-1];
    assign w_mag_a = w_neg_a ? -a_i : a_i;
    assign w_mag_b = w_neg_b ? -b_i : b_i;
    assign w_div0  = (b_i == '0);
    assign w_ovf   = op_i[2] & ~op_i[1] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);

    // Shift-add multiply step
    assign w_addend = lo_q[0] ? m_q : '0;
    assign w_sum    = {1'b0, hi_q} + {1'b0, w_addend};

    // Restoring divide step; the difference fits XLEN bits whenever it is kept
    assign w_rsh  = {hi_q, lo_q[XLEN-1]};
    assign w_ge   = (w_rsh >= {1'b0, m_q});
    assign w_diff = w_rsh[XLEN-1:0] - m_q;

    // Sign fix-up and word selection
    assign w_prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign w_quot = neg_q ? -lo_q : lo_q;
    assign w_rem  = neg_q ? -hi_q : hi_q;

    assign result_o = op_q[2] ? (op_q[0] ? w_rem : w_quot)
                              : ((op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                                      : w_prod[2*XLEN-1:XLEN]);
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_FIX);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        neg_d   = neg_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    cnt_d = CW'(XLEN);
                    hi_d  = '0;
                    if (op_i[2]) begin
                        m_d     = w_mag_b;
                        lo_d    = w_mag_a;
                        neg_d   = op_i[0] ? w_neg_a : (w_neg_a ^ w_neg_b);
                        state_d = ST_DIV;
                        // Special cases preload final quotient/remainder
                        if (w_div0) begin
                            hi_d    = a_i;
                            lo_d    = '1;
                            neg_d   = 1'b0;
                            state_d = ST_FIX;
                        end else if (w_ovf) begin
                            lo_d    = a_i;
                            neg_d   = 1'b0;
                            state_d = ST_FIX;
                        end
                    end else begin
                        m_d     = w_mag_a;
                        lo_d    = w_mag_b;
                        neg_d   = w_neg_a ^ w_neg_b;
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                {hi_d, lo_d} = {w_sum, lo_q[XLEN-1:1]};
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                hi_d  = w_ge ? w_diff : w_rsh[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], w_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU. Single-cycle logic/shift/compare/add ops
//               are registered directly; MUL*/DIV/REM run in muldiv_core.
//               Build macro FAST_MUL_EN: multiplies use a combinational
//               2*XLEN multiplier with single-cycle latency instead of the
//               iterative engine (divide stays iterative).
// Ports       : CLK, RESET (sync, active-low), VALID_IN/READY_OUT request
//               handshake, ALU_OP, DATA1, DATA2, FLUSH (abort in-flight op),
//               VALID_OUT (1-cycle pulse), RESULT, ILLEGAL_OP
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_defs_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            VALID_IN,
    input  logic [4:0]      ALU_OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            READY_OUT,
    output logic            VALID_OUT,
    output logic [XLEN-1:0] RESULT,
    output logic            ILLEGAL_OP
);

    localparam int SHW = $clog2(XLEN);

    logic            w_busy, w_done, w_accept, w_start, w_is_mul, w_is_div;
    logic            w_illegal;
    logic [XLEN-1:0] w_md_res, w_alu_res;
    logic [SHW-1:0]  w_shamt;

    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d, illegal_q, illegal_d;

    assign READY_OUT = ~w_busy;
    assign w_accept  = VALID_IN & READY_OUT & ~FLUSH;
    assign w_is_mul  = (ALU_OP[4:2] == 3'b110);
    assign w_is_div  = (ALU_OP[4:2] == 3'b111);
    assign w_shamt   = DATA2[SHW-1:0];

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    // Sign-extending to 2*XLEN makes the truncated product exact for every
    // signed/unsigned operand combination.
    assign w_fa    = {{XLEN{(ALU_OP != ALU_MULHU) & DATA1[XLEN-1]}}, DATA1};
    assign w_fb    = {{XLEN{~ALU_OP[1] & DATA2[XLEN-1]}}, DATA2};
    assign w_fprod = w_fa * w_fb;
    assign w_start = w_accept & w_is_div;
`else
    assign w_start = w_accept & (w_is_mul | w_is_div);
`endif

    // Mul/div codes reaching the default arm are always routed to the
    // engine via w_start, so their illegal flag is never registered.
    always_comb begin
        w_alu_res = '0;
        w_illegal = 1'b0;
        case (ALU_OP)
            ALU_ADD:  w_alu_res = DATA1 + DATA2;
            ALU_SUB:  w_alu_res = DATA1 - DATA2;
            ALU_SLL:  w_alu_res = DATA1 << w_shamt;
            ALU_SRL:  w_alu_res = DATA1 >> w_shamt;
            ALU_SRA:  w_alu_res = $signed(DATA1) >>> w_shamt;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (DATA1 < DATA2)};
            ALU_XOR:  w_alu_res = DATA1 ^ DATA2;
            ALU_OR:   w_alu_res = DATA1 | DATA2;
            ALU_AND:  w_alu_res = DATA1 & DATA2;
`ifdef FAST_MUL_EN
            ALU_MUL:    w_alu_res = w_fprod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  w_alu_res = w_fprod[2*XLEN-1:XLEN];
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_muldiv_core (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .start_i  (w_start),
        .op_i     ({w_is_div, ALU_OP[1:0]}),
        .a_i      (DATA1),
        .b_i      (DATA2),
        .flush_i  (FLUSH),
        .busy_o   (w_busy),
        .done_o   (w_done),
        .result_o (w_md_res)
    );

    // Engine completion and single-cycle accepts are mutually exclusive:
    // accepting needs IDLE, completing happens in FIX.
    always_comb begin
        result_d  = result_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (w_done && !FLUSH) begin
            result_d = w_md_res;
            valid_d  = 1'b1;
        end else if (w_accept && !w_start) begin
            result_d  = w_alu_res;
            valid_d   = 1'b1;
            illegal_d = w_illegal;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            result_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign VALID_OUT  = valid_q;
    assign RESULT     = result_q;
    assign ILLEGAL_OP = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. A behavioural model
//               computes each result with 64-bit arithmetic and tracks the
//               expected latency; a compare process checks the outputs every
//               cycle. Honors FAST_MUL_EN for multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        CLK = 1'b0;
    logic        RESET, VALID_IN, FLUSH;
    logic [4:0]  ALU_OP;
    logic [31:0] DATA1, DATA2;
    logic        READY_OUT, VALID_OUT, ILLEGAL_OP;
    logic [31:0] RESULT;

    int total = 0;
    int bad   = 0;

    alu_exec_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .VALID_IN   (VALID_IN),
        .ALU_OP     (ALU_OP),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .FLUSH      (FLUSH),
        .READY_OUT  (READY_OUT),
        .VALID_OUT  (VALID_OUT),
        .RESULT     (RESULT),
        .ILLEGAL_OP (ILLEGAL_OP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: result, illegal flag and edges after accept until VALID_OUT
    // (0 means the result is registered at the accepting edge itself).
    function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic il, output int lat);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        sh = int'(b[4:0]);
        r = '0; il = 1'b0; lat = 0;
        case (op)
            5'b00000: r = a + b;
            5'b00001: r = a << sh;
            5'b00010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b00100: r = a ^ b;
            5'b00101: r = a >> sh;
            5'b00110: r = a | b;
            5'b00111: r = a & b;
            5'b10000: r = a - b;
            5'b10101: r = $signed(a) >>> sh;
            5'b11000: begin p = sa * sb; r = p[31:0];  lat = MUL_LAT; end
            5'b11001: begin p = sa * sb; r = p[63:32]; lat = MUL_LAT; end
            5'b11010: begin p = sa * longint'(ub); r = p[63:32]; lat = MUL_LAT; end
            5'b11011: begin pu = ua * ub; r = pu[63:32]; lat = MUL_LAT; end
            5'b11100, 5'b11101: begin
                lat = 33;
                if (b == 0) begin
                    r = (op == 5'b11100) ? 32'hFFFF_FFFF : a; lat = 1;
                end else if (a == MIN && b == 32'hFFFF_FFFF) begin
                    r = (op == 5'b11100) ? MIN : 32'd0; lat = 1;
                end else begin
                    p = (op == 5'b11100) ? (sa / sb) : (sa % sb);
                    r = p[31:0];
                end
            end
            5'b11110, 5'b11111: begin
                lat = 33;
                if (b == 0) begin
                    r = (op == 5'b11110) ? 32'hFFFF_FFFF : a; lat = 1;
                end else begin
                    r = (op == 5'b11110) ? (a / b) : (a % b);
                end
            end
            default: il = 1'b1;
        endcase
    endfunction

    // ---------------- behavioural model (updated at each edge) ----------------
    bit          m_started = 0, m_busy = 0, m_acc = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    bit          e_valid = 0, e_ill = 0, e_rst = 0;
    logic [31:0] e_res = '0;

    initial begin
        logic [31:0] r;
        logic        il;
        int          lat;
        bit          rdy;
        forever begin
            @(posedge CLK);
            m_started = 1;
            e_valid = 0; e_ill = 0; e_rst = 0; m_acc = 0;
            if (!RESET) begin
                m_busy = 0; m_left = 0; e_rst = 1;
            end else begin
                rdy = !m_busy;
                if (m_busy) begin
                    if (FLUSH) m_busy = 0;
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_busy = 0; e_valid = 1; e_res = m_res;
                        end
                    end
                end
                if (rdy && VALID_IN && !FLUSH) begin
                    ref_op(ALU_OP, DATA1, DATA2, r, il, lat);
                    m_acc = 1;
                    if (lat == 0) begin
                        e_valid = 1; e_res = r; e_ill = il;
                    end else begin
                        m_busy = 1; m_left = lat; m_res = r;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (m_started) begin
                chk("valid_out", 32'(VALID_OUT), 32'(e_valid));
                chk("ready_out", 32'(READY_OUT), 32'(!m_busy));
                chk("illegal_op", 32'(ILLEGAL_OP), 32'(e_ill));
                if (e_valid) chk("result", RESULT, e_res);
                if (e_rst)   chk("reset_result", RESULT, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit fl, input bit rs);
        VALID_IN = v; ALU_OP = op; DATA1 = a; DATA2 = b; FLUSH = fl; RESET = rs;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    // Holds the request until the model reports acceptance (bounded).
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            drive(1'b1, op, a, b, 1'b0, 1'b1);
            got = m_acc;
        end
        VALID_IN = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout: op %b not accepted within 60 cycles", op);
        end
    endtask

    task automatic pin(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input bit eil, input int elat);
        logic [31:0] r;
        logic        il;
        int          lat;
        ref_op(op, a, b, r, il, lat);
        chk({nm, "_res"}, r, er);
        chk({nm, "_ill"}, 32'(il), 32'(eil));
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] legal_ops [18] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                   5'b00110, 5'b00111, 5'b10000, 5'b10101, 5'b11000, 5'b11001,
                                   5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111};

    initial begin
        // Pin the model against hand-computed values
        pin("add",    5'b00000, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, 0);
        pin("sra",    5'b10101, MIN, 32'd4, 32'hF800_0000, 1'b0, 0);
        pin("mulh",   5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, MUL_LAT);
        pin("mulhu",  5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
        pin("div0",   5'b11100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        pin("rem0",   5'b11101, 32'd7, 32'd0, 32'd7, 1'b0, 1);
        pin("divovf", 5'b11100, MIN, 32'hFFFF_FFFF, MIN, 1'b0, 1);
        pin("remneg", 5'b11101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        pin("divu",   5'b11110, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        pin("remu",   5'b11111, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        pin("illegal",5'b01000, 32'd5, 32'd6, 32'd0, 1'b1, 0);
        pin("mul",    5'b11000, 32'd6, 32'd7, 32'd42, 1'b0, MUL_LAT);

        // Reset
        VALID_IN = 0; ALU_OP = 0; DATA1 = 0; DATA2 = 0; FLUSH = 0; RESET = 0;
        repeat (2) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(2);

        // Single-cycle ops
        issue(5'b00000, 32'd7, 32'hFFFF_FFFD);
        issue(5'b10101, MIN, 32'd4);
        idle(2);
        // Iterative multiply; second request accepted alongside VALID_OUT
        issue(5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(40);
        // Divide short-circuits and normal divides
        issue(5'b11100, 32'd7, 32'd0);
        issue(5'b11101, 32'd7, 32'd0);
        issue(5'b11100, MIN, 32'hFFFF_FFFF);
        issue(5'b11101, 32'hFFFF_FFF9, 32'd2);
        issue(5'b11110, 32'd100, 32'd7);
        issue(5'b11111, 32'd100, 32'd7);
        idle(40);
        // FLUSH sampled at E10 of a divide
        issue(5'b11100, 32'd1000, 32'd3);
        idle(9);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(2);
        issue(5'b01000, 32'd5, 32'd6);
        idle(2);
        // RESET sampled at E5 of a multiply
        issue(5'b11000, 32'd5, 32'd9);
        idle(4);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(3);
        issue(5'b11000, 32'd6, 32'd7);
        idle(40);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 17)];
            drive($urandom_range(0, 3) != 0, op, rnd_operand(), rnd_operand(),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 799) != 0);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
